// File: rtl/uart_host_if.sv
// Host-side buffering between system logic and a UART core: a TX byte FIFO drained
// through a start/done handshake, and an RX byte FIFO with a sticky overflow flag.
module uart_host_if #(
  parameter int DBIT_WIDTH = 8,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_tx_valid,
  output logic                        s_tx_ready,
  input  logic [DBIT_WIDTH-1:0]       s_tx_data,
  output logic                        m_rx_valid,
  input  logic                        m_rx_ready,
  output logic [DBIT_WIDTH-1:0]       m_rx_data,
  output logic                        uart_tx_start,
  output logic [DBIT_WIDTH-1:0]       uart_tx_data,
  input  logic                        uart_tx_done,
  input  logic                        uart_rx_done,
  input  logic [DBIT_WIDTH-1:0]       uart_rx_data,
  input  logic                        clr_overflow,
  output logic                        rx_overflow,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic                        tx_idle
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_BUSY  = 2'd2
  } tx_state_t;

  tx_state_t tx_state, tx_state_nxt;

  logic [DBIT_WIDTH-1:0] tx_mem [TX_DEPTH];
  logic [TX_AW:0]        tx_wr_ptr, tx_rd_ptr;
  logic                  tx_empty, tx_full, tx_push, tx_pop;

  logic [DBIT_WIDTH-1:0] rx_mem [RX_DEPTH];
  logic [RX_AW:0]        rx_wr_ptr, rx_rd_ptr;
  logic                  rx_empty, rx_full, rx_push, rx_pop, rx_drop;

  // ---------------- TX FIFO ----------------
  // The extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign tx_empty   = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full    = (tx_wr_ptr[TX_AW] != tx_rd_ptr[TX_AW]) &&
                      (tx_wr_ptr[TX_AW-1:0] == tx_rd_ptr[TX_AW-1:0]);
  assign tx_level   = tx_wr_ptr - tx_rd_ptr;
  assign s_tx_ready = !tx_full;
  assign tx_push    = s_tx_valid && !tx_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr[TX_AW-1:0]] <= s_tx_data;
  end

  // ---------------- TX FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_pop       = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_state_nxt = TX_START;
          tx_pop       = 1'b1;
        end
      end
      TX_START: tx_state_nxt = TX_BUSY;
      TX_BUSY:  if (uart_tx_done) tx_state_nxt = TX_IDLE;
      default:  tx_state_nxt = TX_IDLE;
    endcase
  end

  // Start is decoded from state so an async reset drops it without waiting for an edge.
  assign uart_tx_start = (tx_state == TX_START);
  assign tx_idle       = (tx_state == TX_IDLE) && tx_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      uart_tx_data <= '0;
    else if (tx_pop) uart_tx_data <= tx_mem[tx_rd_ptr[TX_AW-1:0]];
  end

  // ---------------- RX FIFO ----------------
  assign rx_empty   = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full    = (rx_wr_ptr[RX_AW] != rx_rd_ptr[RX_AW]) &&
                      (rx_wr_ptr[RX_AW-1:0] == rx_rd_ptr[RX_AW-1:0]);
  assign rx_level   = rx_wr_ptr - rx_rd_ptr;
  assign m_rx_valid = !rx_empty;
  assign m_rx_data  = rx_mem[rx_rd_ptr[RX_AW-1:0]];
  assign rx_pop     = m_rx_valid && m_rx_ready;
  // When full, a simultaneous pop frees the head slot, which the write then reuses as the tail.
  assign rx_push    = uart_rx_done && (!rx_full || rx_pop);
  assign rx_drop    = uart_rx_done && rx_full && !rx_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr[RX_AW-1:0]] <= uart_rx_data;
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            rx_overflow <= 1'b0;
    else if (rx_drop)      rx_overflow <= 1'b1;
    else if (clr_overflow) rx_overflow <= 1'b0;
  end

endmodule

// File: tb/tb_uart_host_if.sv
// Scoreboard bench for uart_host_if: TX ordering/handshake, RX FIFO order,
// overflow flag behaviour and asynchronous reset mid-transfer.
module tb_uart_host_if;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_tx_valid;
  logic          s_tx_ready;
  logic [DW-1:0] s_tx_data;
  logic          m_rx_valid;
  logic          m_rx_ready;
  logic [DW-1:0] m_rx_data;
  logic          uart_tx_start;
  logic [DW-1:0] uart_tx_data;
  logic          uart_tx_done;
  logic          uart_rx_done;
  logic [DW-1:0] uart_rx_data;
  logic          clr_overflow;
  logic          rx_overflow;
  logic [4:0]    tx_level;
  logic [4:0]    rx_level;
  logic          tx_idle;

  logic done_auto = 1'b0;
  logic done_man  = 1'b0;
  bit   auto_done = 1'b0;
  assign uart_tx_done = done_auto | done_man;

  always #5 clk = ~clk;

  uart_host_if #(.DBIT_WIDTH(DW), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tx_valid(s_tx_valid), .s_tx_ready(s_tx_ready), .s_tx_data(s_tx_data),
    .m_rx_valid(m_rx_valid), .m_rx_ready(m_rx_ready), .m_rx_data(m_rx_data),
    .uart_tx_start(uart_tx_start), .uart_tx_data(uart_tx_data), .uart_tx_done(uart_tx_done),
    .uart_rx_done(uart_rx_done), .uart_rx_data(uart_rx_data),
    .clr_overflow(clr_overflow), .rx_overflow(rx_overflow),
    .tx_level(tx_level), .rx_level(rx_level), .tx_idle(tx_idle)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] tx_exp[$];
  logic [DW-1:0] tx_obs[$];
  logic [DW-1:0] rx_exp[$];

  int cyc = 0;
  int last_done_cyc = -100;
  int double_pulse = 0;
  int gap_viol = 0;
  logic prev_start = 1'b0;

  // Observe TX start pulses, their data, pulse width and spacing from done.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (uart_tx_start) begin
      tx_obs.push_back(uart_tx_data);
      if (prev_start) double_pulse++;
      if (cyc - last_done_cyc < 2) gap_viol++;
    end
    if (uart_tx_done) last_done_cyc = cyc;
    prev_start = uart_tx_start;
  end

  // Model transmitter: done pulse 10 cycles after each start.
  initial forever begin
    @(negedge clk);
    if (uart_tx_start && auto_done) begin
      repeat (10) @(posedge clk);
      #1 done_auto = 1'b1;
      @(posedge clk);
      #1 done_auto = 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_byte(input logic [DW-1:0] b, output bit ok);
    ok = 1'b0;
    s_tx_valid = 1'b1;
    s_tx_data  = b;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_tx_ready) begin
        tx_exp.push_back(b);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) s_tx_valid = 1'b0;
    @(posedge clk); #1;
    s_tx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (tx_obs.size() >= n && tx_idle) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic rx_byte(input logic [DW-1:0] b);
    uart_rx_done = 1'b1;
    uart_rx_data = b;
    if (rx_exp.size() < DEPTH) rx_exp.push_back(b);
    @(posedge clk); #1;
    uart_rx_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_tx_valid = 1'b0; s_tx_data = '0; m_rx_ready = 1'b0;
    uart_rx_done = 1'b0; uart_rx_data = '0; clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (s_tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_tx_ready: got %b want 1", s_tx_ready); end
    n_cmp++; if (m_rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_rx_valid: got %b want 0", m_rx_valid); end
    n_cmp++; if (tx_idle !== 1'b1) begin n_err++; $display("FAIL reset_tx_idle: got %b want 1", tx_idle); end
    n_cmp++; if (uart_tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start: got %b want 0", uart_tx_start); end
    n_cmp++; if (uart_tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", uart_tx_data); end
    n_cmp++; if (rx_overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", rx_overflow); end
    n_cmp++; if (tx_level !== 5'd0) begin n_err++; $display("FAIL reset_tx_level: got %0d want 0", tx_level); end
    n_cmp++; if (rx_level !== 5'd0) begin n_err++; $display("FAIL reset_rx_level: got %0d want 0", rx_level); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_tx();
    bit ok;
    logic [DW-1:0] e, o;
    tx_exp.delete(); tx_obs.delete();
    double_pulse = 0; gap_viol = 0;
    auto_done = 1'b1;
    push_byte(8'hA5, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_push_a5: accepted %b want 1", ok); end
    push_byte(8'hC3, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_push_c3: accepted %b want 1", ok); end
    wait_tx(2, 200, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_drain_timeout: starts %0d want 2", tx_obs.size()); end
    n_cmp++; if (tx_obs.size() !== 2) begin n_err++; $display("FAIL basic_start_count: got %0d want 2", tx_obs.size()); end
    while (tx_exp.size() > 0 && tx_obs.size() > 0) begin
      e = tx_exp.pop_front(); o = tx_obs.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL basic_tx_data: got %h want %h", o, e); end
    end
    n_cmp++; if (double_pulse !== 0) begin n_err++; $display("FAIL basic_pulse_width: multi-cycle pulses %0d want 0", double_pulse); end
    n_cmp++; if (gap_viol !== 0) begin n_err++; $display("FAIL basic_done_gap: violations %0d want 0", gap_viol); end
    n_cmp++; if (tx_idle !== 1'b1) begin n_err++; $display("FAIL basic_tx_idle: got %b want 1", tx_idle); end
  endtask

  task automatic test_tx_full();
    bit ok;
    int accepted;
    logic [DW-1:0] e, o;
    tx_exp.delete(); tx_obs.delete();
    auto_done = 1'b0;
    accepted = 0;
    s_tx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_tx_data = 8'h40 + 8'(i);
      @(negedge clk);
      if (s_tx_ready) begin
        tx_exp.push_back(s_tx_data);
        accepted++;
      end
      @(posedge clk); #1;
    end
    s_tx_valid = 1'b0;
    n_cmp++; if (accepted !== DEPTH + 1) begin n_err++; $display("FAIL full_accepted: got %0d want %0d", accepted, DEPTH + 1); end
    n_cmp++; if (s_tx_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", s_tx_ready); end
    n_cmp++; if (tx_level !== 5'd16) begin n_err++; $display("FAIL full_level: got %0d want 16", tx_level); end
    auto_done = 1'b1;
    done_man = 1'b1;
    @(posedge clk); #1;
    done_man = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (s_tx_ready) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL full_ready_return: got %b want 1", s_tx_ready); end
    @(posedge clk); #1;
    wait_tx(DEPTH + 1, 800, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL full_drain_timeout: starts %0d want %0d", tx_obs.size(), DEPTH + 1); end
    n_cmp++; if (tx_obs.size() !== tx_exp.size()) begin n_err++; $display("FAIL full_count: got %0d want %0d", tx_obs.size(), tx_exp.size()); end
    while (tx_exp.size() > 0 && tx_obs.size() > 0) begin
      e = tx_exp.pop_front(); o = tx_obs.pop_front();
      n_cmp++; if (o !== e) begin n_err++; $display("FAIL full_order: got %h want %h", o, e); end
    end
    auto_done = 1'b0;
  endtask

  task automatic test_rx_basic();
    logic [DW-1:0] e;
    rx_exp.delete();
    m_rx_ready = 1'b0;
    rx_byte(8'h11); rx_byte(8'h22); rx_byte(8'h33);
    n_cmp++; if (rx_level !== 5'd3) begin n_err++; $display("FAIL rx_level3: got %0d want 3", rx_level); end
    n_cmp++; if (m_rx_data !== rx_exp[0]) begin n_err++; $display("FAIL rx_head: got %h want %h", m_rx_data, rx_exp[0]); end
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if (m_rx_data !== rx_exp[0]) begin n_err++; $display("FAIL rx_head_stable: got %h want %h", m_rx_data, rx_exp[0]); end
    m_rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = rx_exp.pop_front();
      n_cmp++; if (m_rx_valid !== 1'b1 || m_rx_data !== e) begin n_err++; $display("FAIL rx_order: got v=%b %h want v=1 %h", m_rx_valid, m_rx_data, e); end
      @(posedge clk); #1;
    end
    m_rx_ready = 1'b0;
    n_cmp++; if (m_rx_valid !== 1'b0) begin n_err++; $display("FAIL rx_empty_valid: got %b want 0", m_rx_valid); end
    n_cmp++; if (rx_level !== 5'd0) begin n_err++; $display("FAIL rx_empty_level: got %0d want 0", rx_level); end
  endtask

  task automatic test_rx_overflow();
    rx_exp.delete();
    m_rx_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) rx_byte(8'h80 + 8'(i));
    n_cmp++; if (rx_level !== 5'd16) begin n_err++; $display("FAIL ovf_level: got %0d want 16", rx_level); end
    n_cmp++; if (rx_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", rx_overflow); end
    n_cmp++; if (m_rx_data !== rx_exp[0]) begin n_err++; $display("FAIL ovf_head: got %h want %h", m_rx_data, rx_exp[0]); end
    clr_overflow = 1'b1;
    @(posedge clk); #1;
    clr_overflow = 1'b0;
    n_cmp++; if (rx_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", rx_overflow); end
    clr_overflow = 1'b1;
    rx_byte(8'hEE);
    clr_overflow = 1'b0;
    n_cmp++; if (rx_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_clear_vs_drop: got %b want 1", rx_overflow); end
    n_cmp++; if (rx_level !== 5'd16) begin n_err++; $display("FAIL ovf_level_after_drop: got %0d want 16", rx_level); end
    clr_overflow = 1'b1;
    @(posedge clk); #1;
    clr_overflow = 1'b0;
    n_cmp++; if (rx_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear2: got %b want 0", rx_overflow); end
  endtask

  task automatic test_rx_full_pop();
    logic [DW-1:0] e;
    uart_rx_done = 1'b1;
    uart_rx_data = 8'h5A;
    m_rx_ready   = 1'b1;
    @(negedge clk);
    e = rx_exp.pop_front();
    n_cmp++; if (m_rx_data !== e) begin n_err++; $display("FAIL fullpop_head: got %h want %h", m_rx_data, e); end
    rx_exp.push_back(8'h5A);
    @(posedge clk); #1;
    uart_rx_done = 1'b0;
    m_rx_ready   = 1'b0;
    n_cmp++; if (rx_level !== 5'd16) begin n_err++; $display("FAIL fullpop_level: got %0d want 16", rx_level); end
    n_cmp++; if (rx_overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_overflow: got %b want 0", rx_overflow); end
    m_rx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      e = rx_exp.pop_front();
      n_cmp++; if (m_rx_valid !== 1'b1 || m_rx_data !== e) begin n_err++; $display("FAIL fullpop_drain: got v=%b %h want v=1 %h", m_rx_valid, m_rx_data, e); end
      @(posedge clk); #1;
    end
    m_rx_ready = 1'b0;
    n_cmp++; if (m_rx_valid !== 1'b0) begin n_err++; $display("FAIL fullpop_empty: got %b want 0", m_rx_valid); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n0;
    tx_exp.delete(); tx_obs.delete();
    auto_done = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'h01 + 8'(i), ok);
    rx_byte(8'h77);
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++; if (tx_level !== 5'd4) begin n_err++; $display("FAIL mid_level_before: got %0d want 4", tx_level); end
    n_cmp++; if (tx_idle !== 1'b0 || uart_tx_data !== 8'h01) begin n_err++; $display("FAIL mid_busy_before: idle=%b data=%h want idle=0 data=01", tx_idle, uart_tx_data); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (uart_tx_start !== 1'b0 || uart_tx_data !== 8'h00) begin n_err++; $display("FAIL mid_async_tx: start=%b data=%h want 0/00", uart_tx_start, uart_tx_data); end
    n_cmp++; if (s_tx_ready !== 1'b1 || tx_level !== 5'd0 || tx_idle !== 1'b1) begin n_err++; $display("FAIL mid_async_txfifo: ready=%b level=%0d idle=%b want 1/0/1", s_tx_ready, tx_level, tx_idle); end
    n_cmp++; if (m_rx_valid !== 1'b0 || rx_level !== 5'd0 || rx_overflow !== 1'b0) begin n_err++; $display("FAIL mid_async_rx: valid=%b level=%0d ovf=%b want 0/0/0", m_rx_valid, rx_level, rx_overflow); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n0 = tx_obs.size();
    @(posedge clk); #1;
    done_man = 1'b1;
    @(posedge clk); #1;
    done_man = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    n_cmp++; if (tx_obs.size() !== n0) begin n_err++; $display("FAIL mid_late_done_start: starts %0d want %0d", tx_obs.size(), n0); end
    n_cmp++; if (tx_idle !== 1'b1) begin n_err++; $display("FAIL mid_late_done_idle: got %b want 1", tx_idle); end
  endtask

  initial begin
    test_reset();
    test_basic_tx();
    test_tx_full();
    test_rx_basic();
    test_rx_overflow();
    test_rx_full_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
